// File: rtl/aw_fetch_sequencer.sv
// Instruction-fetch sequencer for the Another World VM: walks bytecode memory, sizes each
// opcode's operand field and hands one assembled instruction at a time to the execute stage.
module aw_fetch_sequencer #(
  parameter int              AW       = 8,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  output logic          o_mem_rd,
  output logic [AW-1:0] o_mem_addr,
  input  logic [7:0]    i_mem_data,
  input  logic          i_redir_valid,
  input  logic [AW-1:0] i_redir_pc,
  output logic          o_ins_valid,
  input  logic          i_ins_ready,
  output logic [7:0]    o_ins_opcode,
  output logic [47:0]   o_ins_operands,
  output logic [2:0]    o_ins_len,
  output logic [AW-1:0] o_ins_pc,
  output logic          o_ins_illegal,
  output logic          o_busy
);

  typedef enum logic [2:0] {
    S_OPREQ,
    S_OPCAP,
    S_ARGREQ,
    S_ARGCAP,
    S_ISSUE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [2:0]    r_cnt;
  logic [2:0]    r_need;
  logic [7:0]    r_opcode;
  logic [47:0]   r_operands;
  logic          r_illegal;
  logic          r_mem_rd;
  logic [AW-1:0] r_mem_addr;
  logic          r_ins_valid;
  logic          r_busy;

  logic [2:0]    w_opNeed;
  logic          w_opIllegal;
  logic [2:0]    w_cntNext;
  logic [2:0]    w_needNow;
  logic [47:0]   w_slotByte;
  logic [AW-1:0] w_firstArgAddr;
  logic [AW-1:0] w_nextArgAddr;
  logic [AW-1:0] w_nextPc;

  // Operand length from the opcode alone; 0x0A is provisional until its sub-op byte arrives.
  function automatic logic [2:0] fOpNeed(input logic [7:0] op);
    logic [3:0] sum;
    logic [2:0] n;
    sum = 4'd2 + ((op[5:4] == 2'b00) ? 4'd2 : 4'd1)
               + ((op[3:2] == 2'b00) ? 4'd2 : 4'd1)
               + ((op[1:0] == 2'b01 || op[1:0] == 2'b10) ? 4'd1 : 4'd0);
    n = 3'd0;
    if (op[7]) begin
      n = 3'd3;
    end else if (op[6]) begin
      n = (sum > 4'd6) ? 3'd6 : sum[2:0];
    end else begin
      case (op[5:0])
        6'h00, 6'h03, 6'h08, 6'h09, 6'h0C, 6'h14, 6'h15, 6'h16, 6'h17: n = 3'd3;
        6'h01, 6'h02, 6'h04, 6'h07, 6'h0B, 6'h0E, 6'h0F, 6'h13, 6'h19: n = 3'd2;
        6'h0D, 6'h10:                                                  n = 3'd1;
        6'h0A, 6'h12, 6'h18, 6'h1A:                                    n = 3'd5;
        default:                                                       n = 3'd0;
      endcase
    end
    return n;
  endfunction

  function automatic logic [2:0] fSubNeed(input logic [7:0] sub);
    return sub[7] ? 3'd5 : (sub[6] ? 3'd6 : 3'd5);
  endfunction

  assign w_opNeed       = fOpNeed(i_mem_data);
  assign w_opIllegal    = (i_mem_data[7:6] == 2'b00) && (i_mem_data[5:0] > 6'h1A);
  assign w_cntNext      = r_cnt + 3'd1;
  assign w_needNow      = (r_opcode == 8'h0A && r_cnt == 3'd0) ? fSubNeed(i_mem_data) : r_need;
  assign w_slotByte     = {i_mem_data, 40'h0} >> {r_cnt, 3'b000};
  assign w_firstArgAddr = r_pc + AW'(1);
  assign w_nextArgAddr  = r_pc + AW'(1) + AW'(w_cntNext);
  assign w_nextPc       = r_pc + AW'(1) + AW'(r_need);

  // The read strobe for the reset PC is already armed in reset so the first fetch
  // goes out on the very first released edge; it is masked while reset is held.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_OPREQ;
      r_pc        <= RESET_PC;
      r_cnt       <= 3'd0;
      r_need      <= 3'd0;
      r_opcode    <= 8'h00;
      r_operands  <= 48'h0;
      r_illegal   <= 1'b0;
      r_mem_rd    <= 1'b1;
      r_mem_addr  <= RESET_PC;
      r_ins_valid <= 1'b0;
      r_busy      <= 1'b1;
    end else if (i_redir_valid) begin
      r_state     <= S_OPREQ;
      r_pc        <= i_redir_pc;
      r_cnt       <= 3'd0;
      r_need      <= 3'd0;
      r_opcode    <= 8'h00;
      r_operands  <= 48'h0;
      r_illegal   <= 1'b0;
      r_mem_rd    <= 1'b1;
      r_mem_addr  <= i_redir_pc;
      r_ins_valid <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        S_OPREQ: begin
          r_state  <= S_OPCAP;
          r_mem_rd <= 1'b0;
        end
        S_OPCAP: begin
          r_opcode  <= i_mem_data;
          r_need    <= w_opNeed;
          r_illegal <= w_opIllegal;
          if (w_opNeed == 3'd0) begin
            r_state     <= S_ISSUE;
            r_ins_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_state    <= S_ARGREQ;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_firstArgAddr;
          end
        end
        S_ARGREQ: begin
          r_state  <= S_ARGCAP;
          r_mem_rd <= 1'b0;
        end
        S_ARGCAP: begin
          r_operands <= r_operands | w_slotByte;
          r_cnt      <= w_cntNext;
          r_need     <= w_needNow;
          if (w_cntNext == w_needNow) begin
            r_state     <= S_ISSUE;
            r_ins_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_state    <= S_ARGREQ;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_nextArgAddr;
          end
        end
        S_ISSUE: begin
          if (i_ins_ready) begin
            r_state     <= S_OPREQ;
            r_pc        <= w_nextPc;
            r_cnt       <= 3'd0;
            r_operands  <= 48'h0;
            r_ins_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_mem_rd    <= 1'b1;
            r_mem_addr  <= w_nextPc;
          end
        end
        default: begin
          r_state <= S_OPREQ;
        end
      endcase
    end
  end

  assign o_mem_rd       = r_mem_rd & i_reset;
  assign o_busy         = r_busy & i_reset;
  assign o_mem_addr     = r_mem_addr;
  assign o_ins_valid    = r_ins_valid;
  assign o_ins_opcode   = r_opcode;
  assign o_ins_operands = r_operands;
  assign o_ins_len      = r_need;
  assign o_ins_pc       = r_pc;
  assign o_ins_illegal  = r_illegal;

endmodule

// File: tb/tb_aw_fetch_sequencer.sv
// Scoreboard bench for aw_fetch_sequencer: a byte-array memory, an opcode-length reference
// model, directed latency/wrap/redirect cases and randomized programs with random redirects.
module tb_aw_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memRd;
  logic [7:0]  memAddr;
  logic [7:0]  memData = 8'h00;
  logic        redirValid = 1'b0;
  logic [7:0]  redirPc = 8'h00;
  logic        insValid;
  logic        insReady = 1'b0;
  logic [7:0]  insOpcode;
  logic [47:0] insOperands;
  logic [2:0]  insLen;
  logic [7:0]  insPc;
  logic        insIllegal;
  logic        busy;

  int vectors = 0;
  int errors = 0;
  bit monOn = 1'b0;
  bit rndReady = 1'b0;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0]  op;
    logic [47:0] opr;
    logic [2:0]  len;
    logic [7:0]  pc;
    logic        ill;
  } insT;

  insT expQ[$];
  insT monAct;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memRd) memData <= mem[memAddr];
  end

  aw_fetch_sequencer #(.AW(8), .RESET_PC(8'h00)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .o_mem_rd       (memRd),
    .o_mem_addr     (memAddr),
    .i_mem_data     (memData),
    .i_redir_valid  (redirValid),
    .i_redir_pc     (redirPc),
    .o_ins_valid    (insValid),
    .i_ins_ready    (insReady),
    .o_ins_opcode   (insOpcode),
    .o_ins_operands (insOperands),
    .o_ins_len      (insLen),
    .o_ins_pc       (insPc),
    .o_ins_illegal  (insIllegal),
    .o_busy         (busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Opcodes whose field formula exceeds the 6-byte operand buffer are kept out of programs.
  function automatic logic [7:0] rndByte();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255)); while (v == 8'h41 || v == 8'h42);
    return v;
  endfunction

  function automatic int refLen(input logic [7:0] op, input logic [7:0] sub);
    int tbl[27];
    int n;
    tbl = '{3, 2, 2, 3, 2, 0, 0, 2, 3, 3, 0, 2, 3, 1, 2, 2, 1, 0, 5, 2, 3, 3, 3, 3, 5, 2, 5};
    if (op >= 8'h80) return 3;
    if (op >= 8'h40) begin
      n = 2;
      n += (op[5:4] == 2'b00) ? 2 : 1;
      n += (op[3:2] == 2'b00) ? 2 : 1;
      n += (op[1:0] == 2'b01 || op[1:0] == 2'b10) ? 1 : 0;
      return (n > 6) ? 6 : n;
    end
    if (op == 8'h0A) return sub[7] ? 5 : (sub[6] ? 6 : 5);
    if (op <= 8'h1A) return tbl[op];
    return 0;
  endfunction

  function automatic insT refIns(input logic [7:0] p);
    insT e;
    int len;
    e.op  = mem[p];
    len   = refLen(e.op, mem[8'(p + 1)]);
    e.len = 3'(len);
    e.opr = '0;
    for (int i = 0; i < len; i++) e.opr[47 - 8*i -: 8] = mem[8'(p + 1 + i)];
    e.pc  = p;
    e.ill = (e.op >= 8'h1B && e.op <= 8'h3F);
    return e;
  endfunction

  task automatic pushProgram(input logic [7:0] start, input int n);
    logic [7:0] p;
    insT e;
    p = start;
    for (int i = 0; i < n; i++) begin
      e = refIns(p);
      expQ.push_back(e);
      p = 8'(p + 1 + int'(e.len));
    end
  endtask

  task automatic fillMemory();
    for (int i = 0; i < 256; i++) mem[i] = rndByte();
  endtask

  // Monitor: every cycle an instruction is presented it must equal the head of the queue.
  always @(negedge clk) begin
    if (monOn) begin
      if (insValid) begin
        monAct = '{op: insOpcode, opr: insOperands, len: insLen, pc: insPc, ill: insIllegal};
        if (expQ.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected issue: got %0h, expected none", monAct);
        end else begin
          checkOutput("issued instruction", 128'(monAct), 128'(expQ[0]));
          if (insReady) void'(expQ.pop_front());
        end
        checkOutput("mem_rd in ISSUE", 128'(memRd), 128'(0));
        checkOutput("busy in ISSUE", 128'(busy), 128'(0));
      end else begin
        checkOutput("busy outside ISSUE", 128'(busy), 128'(1));
      end
    end
  end

  always @(posedge clk) begin
    if (rndReady) begin
      #1;
      insReady = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic applyReset();
    monOn = 1'b0;
    rndReady = 1'b0;
    reset = 1'b0;
    redirValid = 1'b0;
    repeat (2) @(posedge clk);
    insReady = 1'b0;
    @(negedge clk);
    checkOutput("reset outputs",
                128'({memRd, memAddr, insValid, insOpcode, insOperands, insLen, insPc, insIllegal, busy}),
                128'(0));
  endtask

  // Reset, then redirect straight away so the program starts at p.
  task automatic applyStimulus(input logic [7:0] p);
    applyReset();
    reset = 1'b1;
    redirPc = p;
    redirValid = 1'b1;
    @(posedge clk);
    #1;
    redirValid = 1'b0;
    monOn = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int c = 0; c < budget && expQ.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() != 0) begin
      vectors++;
      errors++;
      $display("[TB] FAIL %s timeout: got %0d pending, expected 0", name, expQ.size());
      expQ.delete();
    end
    monOn = 1'b0;
    rndReady = 1'b0;
  endtask

  task automatic latencyCheck(input int expCycles, input logic [7:0] expNext);
    int cnt;
    cnt = 0;
    reset = 1'b1;
    monOn = 1'b1;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (insValid) break;
    end
    checkOutput("issue latency", 128'(cnt), 128'(expCycles));
    @(negedge clk);
    checkOutput("next fetch", 128'({memRd, memAddr}), 128'({1'b1, expNext}));
    waitDrain("latency", 5);
  endtask

  initial begin
    logic [7:0] dirOp[7];
    logic [7:0] dirSub[7];
    int         dirLen[7];
    logic [7:0] p;
    insT        e;
    int         redirects;
    bit         seen;

    // Single-byte opcode straight out of reset.
    fillMemory();
    mem[0] = 8'h06;
    applyReset();
    insReady = 1'b1;
    expQ.push_back('{op: 8'h06, opr: 48'h0, len: 3'd0, pc: 8'h00, ill: 1'b0});
    latencyCheck(2, 8'h01);

    // Three operand bytes.
    fillMemory();
    mem[0] = 8'h00; mem[1] = 8'h05; mem[2] = 8'h12; mem[3] = 8'h34;
    applyReset();
    insReady = 1'b1;
    expQ.push_back('{op: 8'h00, opr: 48'h051234000000, len: 3'd3, pc: 8'h00, ill: 1'b0});
    latencyCheck(8, 8'h04);

    // Variable-length and computed-length opcodes laid out back to back.
    dirOp  = '{8'h0A, 8'h0A, 8'h0A, 8'h40, 8'h7F, 8'h90, 8'h25};
    dirSub = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    dirLen = '{5, 6, 5, 6, 4, 3, 0};
    fillMemory();
    p = 8'h10;
    for (int i = 0; i < 7; i++) begin
      mem[p] = dirOp[i];
      if (dirOp[i] == 8'h0A) mem[8'(p + 1)] = dirSub[i];
      e.op  = dirOp[i];
      e.len = 3'(dirLen[i]);
      e.opr = '0;
      for (int k = 0; k < dirLen[i]; k++) e.opr[47 - 8*k -: 8] = mem[8'(p + 1 + k)];
      e.pc  = p;
      e.ill = (dirOp[i] == 8'h25);
      expQ.push_back(e);
      p = 8'(p + 1 + dirLen[i]);
    end
    applyStimulus(8'h10);
    insReady = 1'b1;
    waitDrain("directed lengths", 400);

    // Instruction straddling the top of the address space.
    fillMemory();
    mem[8'hFE] = 8'h90;
    mem[8'h02] = 8'h06;
    expQ.push_back('{op: 8'h90, opr: {mem[8'hFF], mem[8'h00], mem[8'h01], 24'h0},
                     len: 3'd3, pc: 8'hFE, ill: 1'b0});
    expQ.push_back('{op: 8'h06, opr: 48'h0, len: 3'd0, pc: 8'h02, ill: 1'b0});
    applyStimulus(8'hFE);
    insReady = 1'b1;
    waitDrain("wrap", 100);

    // Back-pressure: hold the instruction for five cycles, then accept it.
    fillMemory();
    mem[8'h50] = 8'h06;
    expQ.push_back('{op: 8'h06, opr: 48'h0, len: 3'd0, pc: 8'h50, ill: 1'b0});
    applyStimulus(8'h50);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = insValid;
    end
    checkOutput("hold reached ISSUE", 128'(seen), 128'(1));
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    insReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("fetch after hold", 128'({memRd, memAddr}), 128'({1'b1, 8'h51}));
    waitDrain("hold", 5);

    // Redirect while collecting operands of a 5-byte opcode.
    fillMemory();
    mem[8'h20] = 8'h12;
    pushProgram(8'h40, 3);
    applyStimulus(8'h20);
    insReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    redirPc = 8'h40;
    redirValid = 1'b1;
    @(posedge clk);
    #1;
    redirValid = 1'b0;
    waitDrain("redirect", 300);

    // Random programs, random back-pressure and random redirects.
    for (int seg = 0; seg < 8; seg++) begin
      fillMemory();
      p = rndByte();
      pushProgram(p, 10);
      applyStimulus(p);
      rndReady = 1'b1;
      redirects = 0;
      for (int c = 0; c < 3000 && expQ.size() != 0; c++) begin
        @(negedge clk);
        #1;
        if (redirects < 3 && $urandom_range(0, 39) == 0) begin
          expQ.delete();
          p = rndByte();
          pushProgram(p, 10);
          redirPc = p;
          redirValid = 1'b1;
          @(posedge clk);
          #1;
          redirValid = 1'b0;
          redirects++;
        end
      end
      waitDrain("random segment", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
